// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM request front-end:
//   - seq_state_e : sequencer FSM state encoding
//   - CMD_*       : SDRAM command codes {CS_N, RAS_N, CAS_N, WE_N}
//   - addr_field  : extract a column/row field from a linear address, zero-extended
//                   to the driver's 13-bit address width
//   - addr_bank   : extract the 2-bit bank field from a linear address
// -----------------------------------------------------------------------------
package sdram_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitStart = 2'd1,
        StWaitEnd   = 2'd2,
        StGap       = 2'd3
    } seq_state_e;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;

    // Field of 'width' bits starting at 'lsb'; upper bits of the result are zero.
    function automatic logic [12:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        return 13'((addr >> lsb) & ((32'd1 << width) - 32'd1));
    endfunction

    function automatic logic [1:0] addr_bank(input logic [31:0] addr,
                                             input int unsigned lsb);
        return 2'(addr >> lsb);
    endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// -----------------------------------------------------------------------------
// sdram_req_fifo
// Synchronous first-word-fall-through FIFO holding pending client requests.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset, empties the FIFO
//   push   in   write wdata (ignored when full)
//   pop    in   drop head entry (ignored when empty)
//   wdata  in   entry to write
//   rdata  out  head entry, valid while empty=0
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   level  out  occupancy 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
// -----------------------------------------------------------------------------
module sdram_req_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 25,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    level
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sdram_req_sequencer.sv
// -----------------------------------------------------------------------------
// sdram_req_sequencer
// Request front-end for the IS42S16160B SDRAM driver. Client write/read requests
// are queued and replayed one at a time on the driver's active-low start strobes;
// read data is returned on a one-cycle response strobe.
// Ports:
//   CLK_160_COMMON in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   REQ_VALID/READY     client handshake; REQ_READY = FIFO not full
//   REQ_WE         in   1 = write, 0 = read
//   REQ_ADDR       in   linear address {bank[1:0], row, col}
//   REQ_DATA       in   write data
//   RSP_VALID      out  one-cycle pulse qualifying RSP_DATA/RSP_ADDR
//   RSP_DATA/ADDR  out  read data and its address
//   START_WRITE/READ out active-low driver strobes
//   ADDR_ROW/COL   out  13-bit row/column to the driver
//   BANK           out  bank to the driver
//   WR_DATA        out  write data to the driver
//   SDRAM_PROCESS  in   driver busy flag
//   READY_DATA     in   driver read-data-valid level
//   DQ_IN          in   SDRAM data input path
//   ERR            out  sticky: [0] start timeout, [1] read ended without data
//   LEVEL          out  request FIFO occupancy
// -----------------------------------------------------------------------------
module sdram_req_sequencer
    import sdram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned COL_BITS      = 3,
    parameter int unsigned ROW_BITS      = 3,
    parameter int unsigned START_TIMEOUT = 64,
    localparam int unsigned AW = COL_BITS + ROW_BITS + 2,
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          CLK_160_COMMON,
    input  logic          reset,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [15:0]   REQ_DATA,
    output logic          RSP_VALID,
    output logic [15:0]   RSP_DATA,
    output logic [AW-1:0] RSP_ADDR,
    output logic          START_WRITE,
    output logic          START_READ,
    output logic [12:0]   ADDR_ROW,
    output logic [12:0]   ADDR_COL,
    output logic [1:0]    BANK,
    output logic [15:0]   WR_DATA,
    input  logic          SDRAM_PROCESS,
    input  logic          READY_DATA,
    input  logic [15:0]   DQ_IN,
    output logic [1:0]    ERR,
    output logic [LW-1:0] LEVEL
);

    localparam int unsigned   EW       = 1 + AW + 16;
    localparam int unsigned   TW       = $clog2(START_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    // Request FIFO
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [EW-1:0] fifo_wdata;
    logic [EW-1:0] fifo_rdata;
    logic          head_we;
    logic [AW-1:0] head_addr;
    logic [15:0]   head_data;

    // Sequencer state
    seq_state_e    state_q, state_d;
    logic          start_wr_q, start_wr_d;
    logic          start_rd_q, start_rd_d;
    logic [12:0]   row_q, row_d;
    logic [12:0]   col_q, col_d;
    logic [1:0]    bank_q, bank_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          seen_q, seen_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;
    logic [1:0]    err_q, err_d;
    logic          cmd_is_read;

    assign REQ_READY  = !fifo_full;
    assign fifo_push  = REQ_VALID && !fifo_full;
    assign fifo_wdata = {REQ_WE, REQ_ADDR, REQ_DATA};
    assign {head_we, head_addr, head_data} = fifo_rdata;

    // Only start a new command when the driver reports idle.
    assign fifo_pop    = (state_q == StIdle) && !fifo_empty && !SDRAM_PROCESS;
    assign cmd_is_read = (cmd_q == CMD_READ);

    sdram_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (CLK_160_COMMON),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (LEVEL)
    );

    always_comb begin
        state_d     = state_q;
        start_wr_d  = start_wr_q;
        start_rd_d  = start_rd_q;
        row_d       = row_q;
        col_d       = col_q;
        bank_d      = bank_q;
        wr_data_d   = wr_data_q;
        cmd_d       = cmd_q;
        cmd_addr_d  = cmd_addr_q;
        tmo_d       = tmo_q;
        seen_d      = seen_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (fifo_pop) begin
                    row_d      = addr_field(32'(head_addr), COL_BITS, ROW_BITS);
                    col_d      = addr_field(32'(head_addr), 32'd0, COL_BITS);
                    bank_d     = addr_bank(32'(head_addr), COL_BITS + ROW_BITS);
                    wr_data_d  = head_data;
                    cmd_d      = head_we ? CMD_WRITE : CMD_READ;
                    cmd_addr_d = head_addr;
                    start_wr_d = !head_we;
                    start_rd_d = head_we;
                    tmo_d      = '0;
                    seen_d     = 1'b0;
                    state_d    = StWaitStart;
                end
            end

            StWaitStart: begin
                if (SDRAM_PROCESS) begin
                    start_wr_d = 1'b1;
                    start_rd_d = 1'b1;
                    state_d    = StWaitEnd;
                end else if (tmo_q == TMO_LAST) begin
                    // Driver never picked the command up: drop it.
                    start_wr_d = 1'b1;
                    start_rd_d = 1'b1;
                    err_d[0]   = 1'b1;
                    state_d    = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            StWaitEnd: begin
                // Only the first READY_DATA of a read transaction is returned.
                if (cmd_is_read && READY_DATA && !seen_q) begin
                    rsp_data_d  = DQ_IN;
                    rsp_addr_d  = cmd_addr_q;
                    rsp_valid_d = 1'b1;
                    seen_d      = 1'b1;
                end
                if (!SDRAM_PROCESS) begin
                    if (cmd_is_read && !seen_q && !READY_DATA) begin
                        err_d[1] = 1'b1;
                    end
                    state_d = StGap;
                end
            end

            StGap: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK_160_COMMON or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            start_wr_q  <= 1'b1;
            start_rd_q  <= 1'b1;
            row_q       <= '0;
            col_q       <= '0;
            bank_q      <= '0;
            wr_data_q   <= '0;
            cmd_q       <= CMD_NOP;
            cmd_addr_q  <= '0;
            tmo_q       <= '0;
            seen_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            start_wr_q  <= start_wr_d;
            start_rd_q  <= start_rd_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bank_q      <= bank_d;
            wr_data_q   <= wr_data_d;
            cmd_q       <= cmd_d;
            cmd_addr_q  <= cmd_addr_d;
            tmo_q       <= tmo_d;
            seen_q      <= seen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            err_q       <= err_d;
        end
    end

    assign START_WRITE = start_wr_q;
    assign START_READ  = start_rd_q;
    assign ADDR_ROW    = row_q;
    assign ADDR_COL    = col_q;
    assign BANK        = bank_q;
    assign WR_DATA     = wr_data_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_ADDR    = rsp_addr_q;
    assign ERR         = err_q;

endmodule
